// File: rtl/hist_pkg.sv
// Shared definitions for the histogram bin RAM: controller state encoding
// and the counter saturation limit.
package hist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } hist_state_e;

  // All-ones value for a counter of the given width.
  function automatic logic [63:0] sat_limit(input int unsigned width);
    return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/hist_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Only the read register is reset; the array itself is never reset.
module hist_sdp_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_ce,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_ce && i_we && (int'(i_waddr) < DEPTH))
      r_mem[i_waddr] <= i_wdata;
  end

  // Addresses past the end of the array read back as zero.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)
      r_rdata <= '0;
    else if (i_ce && i_re)
      r_rdata <= (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hist_bin_ram.sv
// Histogram bin counters: 2-stage read-modify-write increment pipeline with
// bypass, independent readout port, and a drain-then-zero clear sweep.
module hist_bin_ram
  import hist_pkg::*;
#(
  parameter int C_DATA_WIDTH = 16,
  parameter int C_DEPTH      = 256,
  parameter int C_CE_IN      = 0
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       clk_en_i,
  input  logic                       inc_valid_i,
  input  logic [$clog2(C_DEPTH)-1:0] inc_bin_i,
  output logic                       inc_ready_o,
  input  logic                       clear_i,
  output logic                       busy_o,
  output logic                       clear_done_o,
  input  logic                       rd_en_i,
  input  logic [$clog2(C_DEPTH)-1:0] rd_addr_i,
  output logic [C_DATA_WIDTH-1:0]    rd_data_o,
  output logic                       rd_valid_o
);

  localparam int                    AW      = $clog2(C_DEPTH);
  localparam int                    DW      = C_DATA_WIDTH;
  localparam logic [AW-1:0]         LP_LAST = AW'(C_DEPTH - 1);
  localparam logic [DW-1:0]         LP_SAT  = DW'(sat_limit(C_DATA_WIDTH));

  hist_state_e   r_state;
  logic [AW-1:0] r_clr_addr;

  logic          r_s1_vld, r_s2_vld, r_s3_vld, r_rd_vld;
  logic [AW-1:0] r_s1_bin, r_s2_bin, r_s3_bin;
  logic [DW-1:0] r_s2_data, r_s3_data;

  logic          w_en, w_acc, w_in_range;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_s1_rdata, w_s1_cnt, w_s1_next;

  assign w_en        = (C_CE_IN != 0) ? clk_en_i : 1'b1;
  assign inc_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign w_acc       = w_en & inc_valid_i & inc_ready_o;
  assign w_in_range  = (int'(inc_bin_i) < C_DEPTH);
  assign clear_done_o = w_en & (r_state == ST_CLEAR) & (r_clr_addr == LP_LAST);
  assign rd_valid_o  = w_en & r_rd_vld;

  // DRAIN leaves as soon as S1 is empty: the last S2 write lands on that
  // same edge while the write mux still selects the pipeline.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else if (w_en) begin
      case (r_state)
        ST_IDLE:  if (clear_i) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!r_s1_vld) r_state <= ST_CLEAR;
          r_clr_addr <= '0;
        end
        ST_CLEAR: begin
          if (r_clr_addr == LP_LAST) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + AW'(1);
          end
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
      r_rd_vld <= 1'b0;
    end else if (w_en) begin
      r_s1_vld <= w_acc & w_in_range;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      r_rd_vld <= rd_en_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_en) begin
      r_s1_bin  <= inc_bin_i;
      r_s2_bin  <= r_s1_bin;
      r_s2_data <= w_s1_next;
      r_s3_bin  <= r_s2_bin;
      r_s3_data <= r_s2_data;
    end
  end

  // S3 holds the write that landed on the same edge as S1's read-first
  // lookup, so it is invisible in RAM data; S2 is newer and wins.
  always_comb begin
    w_s1_cnt = w_s1_rdata;
    if (r_s3_vld && (r_s3_bin == r_s1_bin)) w_s1_cnt = r_s3_data;
    if (r_s2_vld && (r_s2_bin == r_s1_bin)) w_s1_cnt = r_s2_data;
  end

  assign w_s1_next = (w_s1_cnt == LP_SAT) ? w_s1_cnt : (w_s1_cnt + DW'(1));

  always_comb begin
    w_we    = r_s2_vld;
    w_waddr = r_s2_bin;
    w_wdata = r_s2_data;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
      w_wdata = '0;
    end
    w_we = w_we & rstn_i;
  end

  hist_sdp_ram #(.DW(DW), .DEPTH(C_DEPTH), .AW(AW)) u_ram_s1 (
    .i_clk   (clk_i),
    .i_rstn  (rstn_i),
    .i_ce    (w_en),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_acc),
    .i_raddr (inc_bin_i),
    .o_rdata (w_s1_rdata)
  );

  hist_sdp_ram #(.DW(DW), .DEPTH(C_DEPTH), .AW(AW)) u_ram_rd (
    .i_clk   (clk_i),
    .i_rstn  (rstn_i),
    .i_ce    (w_en),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (rd_en_i),
    .i_raddr (rd_addr_i),
    .o_rdata (rd_data_o)
  );

endmodule

// File: tb/tb_hist_bin_ram.sv
// Directed bench for hist_bin_ram (4-bit counters, 16 bins, clock enable on).
module tb_hist_bin_ram;

  logic       clk_i = 1'b0;
  logic       rstn_i, clk_en_i, inc_valid_i, clear_i, rd_en_i;
  logic [3:0] inc_bin_i, rd_addr_i;
  logic       inc_ready_o, busy_o, clear_done_o, rd_valid_o;
  logic [3:0] rd_data_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  hist_bin_ram #(.C_DATA_WIDTH(4), .C_DEPTH(16), .C_CE_IN(1)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clk_en_i     (clk_en_i),
    .inc_valid_i  (inc_valid_i),
    .inc_bin_i    (inc_bin_i),
    .inc_ready_o  (inc_ready_o),
    .clear_i      (clear_i),
    .busy_o       (busy_o),
    .clear_done_o (clear_done_o),
    .rd_en_i      (rd_en_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] exp, input string tag);
    rd_en_i   = 1'b1;
    rd_addr_i = a;
    tick();
    rd_en_i = 1'b0;
    chk({tag, "_vld"}, rd_valid_o, 1);
    chk(tag, rd_data_o, exp);
  endtask

  task automatic inc(input logic [3:0] b, input int n);
    inc_valid_i = 1'b1;
    inc_bin_i   = b;
    repeat (n) tick();
    inc_valid_i = 1'b0;
  endtask

  // Counts busy cycles from now until idle; optionally reads bin 7 at
  // sweep step rd_at and expects its pre-clear value rd_exp one cycle later.
  task automatic sweep(input int exp_cyc, input int rd_at, input logic [3:0] rd_exp, input string tag);
    int cnt = 0, ndone = 0, done_at = -1;
    while (busy_o && cnt < 100) begin
      if (clear_done_o) begin ndone++; done_at = cnt; end
      if (cnt == rd_at) begin rd_en_i = 1'b1; rd_addr_i = 4'd7; end
      if (rd_at >= 0 && cnt == rd_at + 1) begin
        rd_en_i = 1'b0;
        chk({tag, "_midrd"}, rd_data_o, rd_exp);
      end
      cnt++;
      tick();
    end
    chk({tag, "_cycles"}, cnt, exp_cyc);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_done_at"}, done_at, exp_cyc - 1);
    chk({tag, "_ready"}, inc_ready_o, 1);
  endtask

  initial begin
    logic [9:0] ce_pat;
    rstn_i = 1'b0; clk_en_i = 1'b1; inc_valid_i = 1'b0; clear_i = 1'b0;
    rd_en_i = 1'b0; inc_bin_i = '0; rd_addr_i = '0;
    tick(); tick();
    chk("rst_busy", busy_o, 1);
    chk("rst_ready", inc_ready_o, 0);
    chk("rst_rdvld", rd_valid_o, 0);
    chk("rst_rddata", rd_data_o, 0);
    chk("rst_done", clear_done_o, 0);

    rstn_i = 1'b1;
    sweep(16, -1, 4'd0, "init");
    for (int i = 0; i < 16; i++) rd(4'(i), 4'd0, $sformatf("init_bin%0d", i));

    inc(4'd3, 5);
    inc(4'd7, 1);
    repeat (3) tick();
    rd(4'd3, 4'd5, "b2b_bin3");
    rd(4'd7, 4'd1, "b2b_bin7");

    inc(4'd4, 1); inc(4'd5, 1); inc(4'd4, 2); inc(4'd5, 1);
    repeat (3) tick();
    rd(4'd4, 4'd3, "aba_bin4");
    rd(4'd5, 4'd2, "aba_bin5");

    inc(4'd0, 20);
    repeat (3) tick();
    rd(4'd0, 4'd15, "sat_bin0");

    ce_pat = 10'b1101001101;
    inc_valid_i = 1'b1;
    inc_bin_i   = 4'd2;
    for (int i = 0; i < 10; i++) begin
      clk_en_i = ce_pat[i];
      tick();
    end
    clk_en_i = 1'b1; inc_valid_i = 1'b0;
    repeat (3) tick();
    rd(4'd2, 4'd6, "ce_bin2");
    clk_en_i = 1'b0; rd_en_i = 1'b1; rd_addr_i = 4'd0;
    tick();
    chk("ce_stall_rdvld", rd_valid_o, 0);
    chk("ce_stall_hold", rd_data_o, 6);
    rd_en_i = 1'b0; clk_en_i = 1'b1;

    clear_i = 1'b1; inc_valid_i = 1'b1; inc_bin_i = 4'd9;
    tick();
    clear_i = 1'b0; inc_valid_i = 1'b0;
    chk("clr_ready", inc_ready_o, 0);
    chk("clr_busy", busy_o, 1);
    sweep(18, 2, 4'd1, "clr");
    for (int i = 0; i < 16; i++) rd(4'(i), 4'd0, $sformatf("clr_bin%0d", i));

    inc(4'd1, 2);
    repeat (3) tick();
    rd(4'd1, 4'd2, "pre_rst_bin1");
    rstn_i = 1'b0; tick(); rstn_i = 1'b1;
    repeat (8) tick();
    chk("mid_busy", busy_o, 1);
    rstn_i = 1'b0; tick(); rstn_i = 1'b1;
    sweep(16, -1, 4'd0, "restart");
    rd(4'd1, 4'd0, "restart_bin1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hist_bin_ram.md
HIST_BIN_RAM -- requirements
Module: hist_bin_ram

Interface
REQ-001 Parameter C_DATA_WIDTH, default 16: bin counter width in bits, >=1.
REQ-002 Parameter C_DEPTH, default 256: number of bins, >=2; AW = $clog2(C_DEPTH).
REQ-003 Parameter C_CE_IN, default 0: 1 = clk_en_i gates all state, 0 = clk_en_i ignored (treated as 1).
REQ-004 The module SHALL use one clock and a synchronous, active-low reset, named as follows:
- clk_i  in  1  clock; all state updates on its rising edge.
- rstn_i  in  1  synchronous active-low reset.
- clk_en_i  in  1  clock enable, honoured only when C_CE_IN=1.
- inc_valid_i  in  1  increment request.
- inc_bin_i  in  AW  bin to increment.
- inc_ready_o  out  1  increments accepted; 0 while clearing or draining.
- clear_i  in  1  request a zeroing sweep of all bins.
- busy_o  out  1  drain or clear sweep in progress.
- clear_done_o  out  1  one-cycle pulse when a sweep completes.
- rd_en_i  in  1  readout request.
- rd_addr_i  in  AW  readout bin.
- rd_data_o  out  C_DATA_WIDTH  readout count.
- rd_valid_o  out  1  rd_data_o valid.

Function
REQ-005 An increment SHALL be accepted on any enabled cycle with inc_valid_i=1 and inc_ready_o=1.
REQ-006 Increments SHALL use a 2-stage read-modify-write pipeline: S1 reads the bin, S2 writes count+1. The new value is in memory 2 enabled cycles after acceptance.
REQ-007 Throughput SHALL be one increment per cycle, including back-to-back hits on the same bin.
REQ-008 When the S2 write address equals the S1 address, S1 SHALL use the S2 write value instead of the memory value, so N consecutive hits add exactly N.
REQ-009 The counter SHALL saturate at 2^C_DATA_WIDTH-1 and SHALL never wrap to 0.
REQ-010 An increment with inc_bin_i >= C_DEPTH SHALL be accepted and discarded, with no memory write.
REQ-011 Readout SHALL have 1-cycle latency: rd_valid_o equals the previous enabled cycle's rd_en_i, and rd_data_o shows memory at rd_addr_i.
- Read is read-first: the result excludes a write to the same bin in the same cycle.
- rd_addr_i >= C_DEPTH returns 0.
- rd_data_o holds its value when rd_en_i=0.
REQ-012 The readout port SHALL stay available in every state; during a sweep it returns 0 for bins already cleared and old data otherwise.
REQ-013 The controller SHALL implement a state machine with states IDLE, DRAIN and CLEAR:
- IDLE -> DRAIN on clear_i=1.
- DRAIN -> CLEAR once S1 and S2 are empty (at most 2 cycles).
- CLEAR writes 0 to address 0..C_DEPTH-1, one per cycle.
- CLEAR -> IDLE after address C_DEPTH-1, with clear_done_o=1 on that transition cycle.
REQ-014 inc_ready_o SHALL be 1 only in IDLE, and busy_o SHALL be 1 in DRAIN and CLEAR.
REQ-015 clear_i SHALL be ignored while busy_o=1, and inc_valid_i SHALL be ignored while inc_ready_o=0.
REQ-016 If clear_i and an accepted increment occur in the same cycle, the increment SHALL enter the pipeline and then be drained before the sweep.
REQ-017 With C_CE_IN=1 and clk_en_i=0, all state, outputs and memory SHALL hold; clear_done_o and rd_valid_o SHALL be 0.

Reset
REQ-018 rstn_i=0 SHALL take effect at the clock edge regardless of clk_en_i.
REQ-019 Reset SHALL clear the pipeline valids and set rd_valid_o=0, rd_data_o=0 and clear_done_o=0.
REQ-020 Reset SHALL load FSM state CLEAR at address 0, so busy_o=1 and inc_ready_o=0 for C_DEPTH enabled cycles after release.
REQ-021 The post-reset sweep SHALL end with a clear_done_o pulse, and SHALL NOT rely on simulation-time memory initialisation.
REQ-022 Reset mid-sweep or mid-pipeline SHALL abort all activity and restart the sweep at address 0.

Structure
REQ-023 Package hist_pkg SHALL hold the FSM state encoding and the saturation-limit helper; C_DATA_WIDTH/C_DEPTH SHALL remain module parameters.
REQ-024 Sub-module hist_sdp_ram (1 write port, 1 registered read port, no reset on the array) SHALL be instantiated twice with identical write buses:
- one copy serves the S1 read;
- the other serves the readout port.
REQ-025 The write mux SHALL select the clear sweep in CLEAR and the S2 write otherwise.

Verification
REQ-026 Release reset, C_DEPTH=16: busy_o=1 for 16 cycles, then clear_done_o pulses once; reading all bins -> all 0.
REQ-027 Send 5 back-to-back increments to bin 3 and 1 to bin 7; 3 cycles later read bin 3 -> 5 and bin 7 -> 1.
REQ-028 C_DATA_WIDTH=4: 20 increments to bin 0 -> reads 15.
REQ-029 Load bins; assert clear_i with an increment in the same cycle: inc_ready_o drops, DRAIN then 16 CLEAR cycles; afterwards all bins read 0.
REQ-030 C_CE_IN=1: toggle clk_en_i low mid-stream of increments to bin 2 -> the final count equals the number of accepted increments, with no duplicates or losses.
REQ-031 Pulse rstn_i low at sweep address 8 -> the sweep restarts at 0 and runs 16 cycles.
